// File: rtl/ctrl_mem_pkg.sv
// Shared types and default sizes for the memory read/write controllers.
//   rd_state_t          : read-controller FSM state encoding
//   MEM_ADDR_WIDTH_DEF  : default memory address width
//   MEM_SIZE_DEF        : default words per sweep
//   DATA_WIDTH_DEF      : default memory word / stream width
package ctrl_mem_pkg;

  localparam int unsigned MEM_ADDR_WIDTH_DEF = 3;
  localparam int unsigned MEM_SIZE_DEF       = 8;
  localparam int unsigned DATA_WIDTH_DEF     = 16;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_READ,
    RD_DRAIN
  } rd_state_t;

endpackage

// File: rtl/ctrl_mem_read_if.sv
// Valid/ready word stream between the read controller and its consumer.
//   m_valid : word valid (producer)
//   m_ready : consumer accepts word
//   m_data  : word payload (producer)
interface ctrl_mem_read_if
  import ctrl_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO used as the read controller's output buffer.
//   clk, reset : clock, synchronous active-high reset
//   push       : write push_data at the tail (caller guarantees not full)
//   pop        : drop the head entry (caller guarantees not empty)
//   push_data  : data to write
//   count      : entries held (0..2)
//   head       : oldest entry
module rd_skid_fifo
  import ctrl_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] slot [2];
  logic                  wr_ptr;
  logic                  rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        slot[wr_ptr] <= push_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = slot[rd_ptr];

endmodule

// File: rtl/ctrl_mem_read.sv
// Memory read controller: sweeps MEM_SIZE words of a synchronous-read memory
// and streams them out on a valid/ready interface at up to 1 word/cycle.
//   clk, reset  : clock, synchronous active-high reset
//   start       : pulse to begin a sweep (ignored while busy)
//   rd_hold     : stall new read issues; buffered words still drain
//   mem_addr    : memory read address
//   mem_rd_en   : memory read strobe (combinational)
//   mem_rd_data : read data, valid the cycle after mem_rd_en
//   m_if        : output word stream (master side)
//   busy        : sweep in progress
//   done        : 1-cycle pulse after the last word is accepted
module ctrl_mem_read
  import ctrl_mem_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = MEM_ADDR_WIDTH_DEF,
  parameter int unsigned MEM_SIZE       = MEM_SIZE_DEF,
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      rd_hold,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic                      mem_rd_en,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data,
  ctrl_mem_read_if.master           m_if,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned CNT_W = $clog2(MEM_SIZE + 1);
  localparam logic [CNT_W-1:0]          CNT_FULL  = CNT_W'(MEM_SIZE);
  localparam logic [CNT_W-1:0]          CNT_LAST  = CNT_W'(MEM_SIZE - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_LAST = MEM_ADDR_WIDTH'(MEM_SIZE - 1);

  rd_state_t             state;
  logic [CNT_W-1:0]      issued;
  logic [CNT_W-1:0]      accepted;
  logic                  inflight;
  logic [1:0]            fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  pop;
  logic [2:0]            occupancy;

  assign pop          = m_if.m_valid & m_if.m_ready;
  assign m_if.m_valid = (fifo_count != 2'd0);
  assign m_if.m_data  = fifo_head;

  // Slots committed after this edge: stored words plus the read in flight,
  // minus the word leaving now. Issue only if that leaves room for one more.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

  always_comb begin
    mem_rd_en = (state == RD_READ) && !rd_hold && (issued < CNT_FULL)
                && (occupancy < 3'd2);
  end

  rd_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .pop       (pop),
    .push_data (mem_rd_data),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RD_IDLE;
      mem_addr <= '0;
      issued   <= '0;
      accepted <= '0;
      inflight <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= mem_rd_en;

      if (mem_rd_en) begin
        mem_addr <= (mem_addr == ADDR_LAST) ? '0 : mem_addr + MEM_ADDR_WIDTH'(1);
        issued   <= issued + CNT_W'(1);
      end
      if (pop) begin
        accepted <= accepted + CNT_W'(1);
      end

      case (state)
        RD_IDLE: begin
          if (start) begin
            state    <= RD_READ;
            busy     <= 1'b1;
            issued   <= '0;
            accepted <= '0;
          end
        end
        RD_READ: begin
          if (mem_rd_en && (issued == CNT_LAST)) begin
            state <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (pop && (accepted == CNT_LAST)) begin
            state <= RD_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= RD_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
